// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
// Holds the FSM state enum, default width, iteration counts and op bundle.
package div_pkg;

   localparam int DEF_XLEN = 64;
   localparam int W_ITERS  = 32;
   localparam int D_ITERS  = 64;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   typedef struct packed {
      logic is_signed;
      logic is_rem;
      logic is_word;
   } op_t;

endpackage

// File: rtl/div_iter_step.sv
// div_iter_step: one combinational restoring-division step.
// Ports: rem/dvs/din in (partial remainder, divisor, next dividend bit);
//        rem_nx/q out (updated remainder, quotient bit).
module div_iter_step
   import div_pkg::*;
#(
   parameter int W = DEF_XLEN
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] dvs,
   input  logic         din,
   output logic [W-1:0] rem_nx,
   output logic         q
);

   logic [W:0] sh;
   logic [W:0] diff;

   // One extra bit: the shifted remainder can reach 2*dvs-1.
   // When the trial subtract fails, sh < dvs so it fits W bits.
   always_comb begin
      sh     = {rem, din};
      diff   = sh - {1'b0, dvs};
      q      = (sh >= {1'b0, dvs});
      rem_nx = q ? diff[W-1:0] : sh[W-1:0];
   end

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: iterative RV64M DIV/DIVU/REM/REMU (+W) unit, 1 bit/cycle.
// Ports: clk, rst (sync, active-high), flush; in_valid/in_ready with
//   is_signed, is_rem, is_word, src1, src2; out_valid/out_ready with
//   result; busy. Optional macro DIV_EARLY_OUT_EN skips the loop for
//   divide-by-zero and signed overflow (result values are unchanged).
module div_seq_ctrl
   import div_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            is_signed,
   input  logic            is_rem,
   input  logic            is_word,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int HW = XLEN / 2;
   localparam int CW = $clog2(D_ITERS);

   state_t          state;
   state_t          state_nx;
   op_t             op;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] dvs;
   logic            neg1;
   logic            neg2;

   logic [XLEN-1:0] step_rem;
   logic            step_q;
   logic            accept;
   logic            early;

   logic [XLEN-1:0] a_ext;
   logic [XLEN-1:0] b_ext;
   logic            s1;
   logic            s2;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;

   logic            neg_q;
   logic [XLEN-1:0] q_fix;
   logic [XLEN-1:0] r_fix;
   logic [XLEN-1:0] res_sel;
   logic [XLEN-1:0] res_fix;

   // Operand conditioning at capture.
   always_comb begin
      a_ext = src1;
      b_ext = src2;
      if (is_word) begin
         a_ext = is_signed ? {{HW{src1[HW-1]}}, src1[HW-1:0]}
                           : {{HW{1'b0}}, src1[HW-1:0]};
         b_ext = is_signed ? {{HW{src2[HW-1]}}, src2[HW-1:0]}
                           : {{HW{1'b0}}, src2[HW-1:0]};
      end
   end

   assign s1    = is_signed & a_ext[XLEN-1];
   assign s2    = is_signed & b_ext[XLEN-1];
   // -MIN wraps to MIN, which read unsigned is the right magnitude.
   assign a_mag = s1 ? -a_ext : a_ext;
   assign b_mag = s2 ? -b_ext : b_ext;

`ifdef DIV_EARLY_OUT_EN
   logic            dz;
   logic            ovf;
   logic [XLEN-1:0] min_v;

   assign min_v = is_word ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}}
                          : {1'b1, {(XLEN-1){1'b0}}};
   assign dz    = (b_ext == '0);
   assign ovf   = is_signed & (a_ext == min_v) & (&b_ext);
   assign early = dz | ovf;
`else
   assign early = 1'b0;
`endif

   assign accept = in_valid & (state == IDLE) & ~flush;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (accept) state_nx = early ? FIX : CALC;
         end
         CALC: if (cnt == '0) state_nx = FIX;
         FIX:  state_nx = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   // Dividend and quotient share quo: dividend bits leave at the top,
   // quotient bits enter at the bottom.
   div_iter_step #(.W(XLEN)) u_step (
      .rem    (rem),
      .dvs    (dvs),
      .din    (quo[XLEN-1]),
      .rem_nx (step_rem),
      .q      (step_q)
   );

   assign neg_q   = op.is_signed & (neg1 ^ neg2) & (|dvs);
   assign q_fix   = neg_q ? -quo : quo;
   assign r_fix   = neg1 ? -rem : rem;
   assign res_sel = op.is_rem ? r_fix : q_fix;
   assign res_fix = op.is_word ? {{HW{res_sel[HW-1]}}, res_sel[HW-1:0]}
                               : res_sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         op     <= '0;
         cnt    <= '0;
         quo    <= '0;
         rem    <= '0;
         dvs    <= '0;
         neg1   <= 1'b0;
         neg2   <= 1'b0;
         result <= '0;
      end else begin
         if (accept) begin
            op   <= '{is_signed: is_signed, is_rem: is_rem, is_word: is_word};
            cnt  <= is_word ? CW'(W_ITERS - 1) : CW'(D_ITERS - 1);
            // W ops: park the 32-bit magnitude in the top half so the
            // loop consumes its bits first.
            quo  <= is_word ? {a_mag[HW-1:0], {HW{1'b0}}} : a_mag;
            rem  <= '0;
            dvs  <= b_mag;
            neg1 <= s1;
            neg2 <= s2;
`ifdef DIV_EARLY_OUT_EN
            // Preload what the full loop would have produced.
            if (dz) begin
               quo <= is_word ? {{HW{1'b0}}, {HW{1'b1}}} : '1;
               rem <= a_mag;
            end else if (ovf) begin
               quo <= a_mag;
            end
`endif
         end else if (state == CALC) begin
            quo <= {quo[XLEN-2:0], step_q};
            rem <= step_rem;
            if (cnt != '0) cnt <= cnt - CW'(1);
         end
         if (state == FIX && !flush) result <= res_fix;
      end
   end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: randomized + directed bench for div_seq_ctrl with
// an arithmetic reference model and a per-cycle compare process.
module tb_div_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic        is_signed;
   logic        is_rem;
   logic        is_word;
   logic [63:0] src1;
   logic [63:0] src2;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

`ifdef DIV_EARLY_OUT_EN
   localparam int ELAT  = 2;
   localparam int ELATW = 2;
`else
   localparam int ELAT  = 66;
   localparam int ELATW = 34;
`endif

   always #5 clk = ~clk;

   div_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .is_signed (is_signed),
      .is_rem    (is_rem),
      .is_word   (is_word),
      .src1      (src1),
      .src2      (src2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // RISC-V M-extension semantics straight from the ISA rules.
   function automatic logic [63:0] ref_div(input bit s, input bit r,
      input bit w, input logic [63:0] a, input logic [63:0] b);
      logic [31:0] a32;
      logic [31:0] b32;
      logic [31:0] r32;
      logic [63:0] r64;
      a32 = a[31:0];
      b32 = b[31:0];
      if (w) begin
         if (b32 == 32'd0)
            r32 = r ? a32 : 32'hFFFF_FFFF;
         else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
            r32 = r ? 32'd0 : a32;
         else if (s && r)
            r32 = $signed(a32) % $signed(b32);
         else if (s)
            r32 = $signed(a32) / $signed(b32);
         else if (r)
            r32 = a32 % b32;
         else
            r32 = a32 / b32;
         return {{32{r32[31]}}, r32};
      end
      if (b == 64'd0)
         r64 = r ? a : '1;
      else if (s && a == MIN && b == '1)
         r64 = r ? 64'd0 : a;
      else if (s && r)
         r64 = $signed(a) % $signed(b);
      else if (s)
         r64 = $signed(a) / $signed(b);
      else if (r)
         r64 = a % b;
      else
         r64 = a / b;
      return r64;
   endfunction

   function automatic int ref_lat(input bit s, input bit w,
      input logic [63:0] a, input logic [63:0] b);
      bit dz;
      bit ov;
      dz = w ? (b[31:0] == 32'd0) : (b == 64'd0);
      ov = s && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                   : (a == MIN && b == '1));
`ifdef DIV_EARLY_OUT_EN
      if (dz || ov) return 2;
`else
      if (dz && ov) return 0;
`endif
      return (w ? 32 : 64) + 2;
   endfunction

   // Reference model: cycle count, busy flag, due cycle, shown result.
   int          cyc     = 0;
   bit          m_busy  = 1'b0;
   int          m_vat   = 0;
   logic [63:0] m_exp   = '0;
   logic [63:0] m_shown = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         m_busy  <= 1'b0;
         m_shown <= '0;
      end else if (flush) begin
         m_busy <= 1'b0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy <= 1'b1;
            m_exp  <= ref_div(is_signed, is_rem, is_word, src1, src2);
            m_vat  <= cyc + ref_lat(is_signed, is_word, src1, src2);
         end
      end else if (cyc >= m_vat) begin
         if (out_ready) m_busy <= 1'b0;
      end else if (cyc + 1 == m_vat) begin
         m_shown <= m_exp;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", 64'(out_valid), 64'(m_busy && cyc >= m_vat));
         chk("in_ready", 64'(in_ready), 64'(!m_busy));
         chk("busy", 64'(busy), 64'(m_busy));
         chk("result", result, m_shown);
      end
   end

   task automatic do_op(input bit s, input bit r, input bit w,
      input logic [63:0] a, input logic [63:0] b, input int hold,
      input bit rnd, output logic [63:0] res, output int lat);
      is_signed = s;
      is_rem    = r;
      is_word   = w;
      src1      = a;
      src2      = b;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         if (rnd) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         lat++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      res = result;
      chk("valid_seen", 64'(out_valid), 64'd1);
      repeat (hold) begin
         @(negedge clk);
         chk("hold_result", result, res);
         chk("hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic dir_op(input string nm, input bit s, input bit r,
      input bit w, input logic [63:0] a, input logic [63:0] b,
      input logic [63:0] exp, input int elat, input int hold);
      logic [63:0] res;
      int          lat;
      do_op(s, r, w, a, b, hold, 1'b0, res, lat);
      chk({nm, "_res"}, res, exp);
      chk({nm, "_lat"}, 64'(lat), 64'(elat));
   endtask

   function automatic logic [63:0] rnd64();
      logic [63:0] v;
      case ($urandom_range(0, 5))
         0:       v = 64'd0;
         1:       v = '1;
         2:       v = MIN;
         3:       v = 64'($urandom_range(0, 20));
         4:       v = -64'($urandom_range(1, 20));
         default: v = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 3) == 0) v[31:0] = 32'h8000_0000;
      return v;
   endfunction

   initial begin
      logic [63:0] res;
      logic [63:0] a;
      logic [63:0] b;
      int          lat;
      bit          s;
      bit          r;
      bit          w;

      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      is_signed = 1'b0;
      is_rem    = 1'b0;
      is_word   = 1'b0;
      src1      = '0;
      src2      = '0;

      // Pin the model against hand-computed values.
      chk("m_divu", ref_div(0, 0, 0, 64'd100, 64'd7), 64'd14);
      chk("m_remu", ref_div(0, 1, 0, 64'd100, 64'd7), 64'd2);
      chk("m_div", ref_div(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3),
          64'hFFFF_FFFF_FFFF_FFFA);
      chk("m_rem", ref_div(1, 1, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3),
          64'hFFFF_FFFF_FFFF_FFFE);
      chk("m_div0", ref_div(1, 0, 0, 64'd5, 64'd0), '1);
      chk("m_rem0", ref_div(1, 1, 0, 64'd5, 64'd0), 64'd5);
      chk("m_ovf", ref_div(1, 0, 0, MIN, '1), MIN);
      chk("m_ovfr", ref_div(1, 1, 0, MIN, '1), 64'd0);
      chk("m_divw", ref_div(1, 0, 1, 64'h1234_5678_8000_0000,
          64'hFFFF_FFFF), 64'hFFFF_FFFF_8000_0000);

      @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_result", result, 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      dir_op("divu", 0, 0, 0, 64'd100, 64'd7, 64'd14, 66, 5);
      dir_op("remu", 0, 1, 0, 64'd100, 64'd7, 64'd2, 66, 0);
      dir_op("div", 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
             64'hFFFF_FFFF_FFFF_FFFA, 66, 1);
      dir_op("rem", 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
             64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
      dir_op("div0", 1, 0, 0, 64'd5, 64'd0, '1, ELAT, 0);
      dir_op("rem0", 1, 1, 0, 64'd5, 64'd0, 64'd5, ELAT, 2);
      dir_op("ovf", 1, 0, 0, MIN, '1, MIN, ELAT, 0);
      dir_op("ovfr", 1, 1, 0, MIN, '1, 64'd0, ELAT, 0);
      dir_op("divw", 1, 0, 1, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF,
             64'hFFFF_FFFF_8000_0000, ELATW, 0);

      // Flush at CALC cycle 10.
      is_signed = 1'b0;
      is_rem    = 1'b0;
      is_word   = 1'b0;
      src1      = 64'd1000;
      src2      = 64'd3;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_result", result, 64'hFFFF_FFFF_8000_0000);
      // Flush beats a same-cycle request in IDLE.
      in_valid = 1'b1;
      flush    = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      chk("flush_idle_busy", 64'(busy), 64'd0);
      repeat (80) @(negedge clk);
      dir_op("post_flush", 0, 0, 0, 64'd1000, 64'd3, 64'd333, 66, 0);

      // Reset mid-op clears the result.
      src1     = 64'd77;
      src2     = 64'd5;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_result", result, 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      dir_op("post_rst", 0, 1, 0, 64'd77, 64'd5, 64'd2, 66, 0);

      for (int i = 0; i < 150; i++) begin
         s = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         a = rnd64();
         b = rnd64();
         do_op(s, r, w, a, b, $urandom_range(0, 3), 1'b1, res, lat);
         chk("rnd_res", res, ref_div(s, r, w, a, b));
         chk("rnd_lat", 64'(lat), 64'(ref_lat(s, w, a, b)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
